clock_sample_multi: RTL and testbench

CLOCK_SAMPLE_MULTI -- requirements
Module: clock_sample_multi

---
 rtl/clock_sample_multi.sv | 175 +++++++++++++++++
 tb/tb_clock_sample_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_sample_multi.sv
// clock_sample_multi
// Samples NUM_CH raw inputs over a window of 2^CNT_WIDTH clock cycles and
// resolves each channel to a stable level. A channel is stable when all but
// STABLE_MARGIN of its samples agree. If any channel is ambiguous, the window
// is retried. After MAX_RETRIES failed windows the block reports a sticky
// failure until the request is dropped. It also keeps a sticky per-channel
// flag that records a resolved 1->0 transition seen while the phase-shift
// step is at or above PS_MIN.
//
// Ports
//   clock                 single clock domain
//   reset                 synchronous, active-high; overrides every other input
//   din                   raw per-channel samples, registered before use
//   sample_req            level request; starts a measurement and holds the result
//   ps_shift_count        current phase-shift step, gates edge detection
//   dout                  resolved channel levels, updated only on a clean window
//   sample_valid          dout is valid for the current request (DONE)
//   sample_error          one-cycle pulse in CHECK when a window is unresolved
//   sample_fail           retries exhausted (FAIL)
//   sample_idle           FSM is in IDLE
//   edge_found            sticky per-channel 1->0 resolved transition flag
//   retry_count           unresolved windows in the current request
//   sampling_timer_count  position inside the current window
module clock_sample_multi #(
  parameter int NUM_CH        = 4,
  parameter int CNT_WIDTH     = 10,
  parameter int STABLE_MARGIN = 0,
  parameter int MAX_RETRIES   = 15,
  parameter int PS_MIN        = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    din,
  input  logic                 sample_req,
  input  logic [7:0]           ps_shift_count,
  output logic [NUM_CH-1:0]    dout,
  output logic                 sample_valid,
  output logic                 sample_error,
  output logic                 sample_fail,
  output logic                 sample_idle,
  output logic [NUM_CH-1:0]    edge_found,
  output logic [7:0]           retry_count,
  output logic [CNT_WIDTH-1:0] sampling_timer_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CHECK  = 3'd2,
    DONE   = 3'd3,
    FAIL   = 3'd4
  } state_e;

  localparam int                   WIN       = 2 ** CNT_WIDTH;
  localparam logic [CNT_WIDTH:0]   HI_THR    = (CNT_WIDTH+1)'(WIN - STABLE_MARGIN);
  localparam logic [CNT_WIDTH:0]   LO_THR    = (CNT_WIDTH+1)'(STABLE_MARGIN);
  localparam logic [CNT_WIDTH:0]   ONES_ONE  = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] TMR_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TMR_MAX   = '1;
  localparam logic [7:0]           RETRY_LIM = 8'(MAX_RETRIES);
  localparam logic [7:0]           PS_MIN_V  = 8'(PS_MIN);

  // Ones counters are one bit wider than the timer so a full window of ones
  // (2^CNT_WIDTH) is representable without wrapping.
  function automatic logic is_high(input logic [CNT_WIDTH:0] ones);
    return ones >= HI_THR;
  endfunction

  function automatic logic is_low(input logic [CNT_WIDTH:0] ones);
    return ones <= LO_THR;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [CNT_WIDTH:0]   ones_q [NUM_CH];
  logic [CNT_WIDTH:0]   ones_d [NUM_CH];
  logic [7:0]           retry_q, retry_d;
  logic [NUM_CH-1:0]    dout_q, dout_d;
  logic [NUM_CH-1:0]    edge_q, edge_d;
  logic [NUM_CH-1:0]    din_q;

  logic [NUM_CH-1:0]    res_hi;
  logic [NUM_CH-1:0]    amb;
  logic                 any_amb;
  logic [7:0]           retry_inc;
  logic                 ps_armed;

  always_comb begin
    res_hi = '0;
    amb    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      res_hi[i] = is_high(ones_q[i]);
      amb[i]    = !is_high(ones_q[i]) && !is_low(ones_q[i]);
    end
  end

  assign any_amb   = |amb;
  assign retry_inc = retry_q + 8'd1;
  assign ps_armed  = (ps_shift_count >= PS_MIN_V);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ones_d  = ones_q;
    retry_d = retry_q;
    dout_d  = dout_q;
    edge_d  = edge_q;
    case (state_q)
      IDLE: begin
        if (sample_req) begin
          state_d = SAMPLE;
          timer_d = '0;
          retry_d = '0;
          for (int i = 0; i < NUM_CH; i++) ones_d[i] = '0;
        end
      end
      SAMPLE: begin
        // sample_req is deliberately not looked at: a window always completes.
        timer_d = timer_q + TMR_ONE;
        for (int i = 0; i < NUM_CH; i++) begin
          if (din_q[i]) ones_d[i] = ones_q[i] + ONES_ONE;
        end
        if (timer_q == TMR_MAX) state_d = CHECK;
      end
      CHECK: begin
        if (any_amb) begin
          retry_d = retry_inc;
          timer_d = '0;
          for (int i = 0; i < NUM_CH; i++) ones_d[i] = '0;
          state_d = (retry_inc == RETRY_LIM) ? FAIL : SAMPLE;
        end else begin
          // All channels load together; a falling resolved level marks the edge.
          dout_d  = res_hi;
          edge_d  = edge_q | (dout_q & ~res_hi & {NUM_CH{ps_armed}});
          state_d = DONE;
        end
      end
      DONE, FAIL: begin
        if (!sample_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      dout_q  <= '0;
      edge_q  <= '0;
      din_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) ones_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      dout_q  <= dout_d;
      edge_q  <= edge_d;
      din_q   <= din;
      for (int i = 0; i < NUM_CH; i++) ones_q[i] <= ones_d[i];
    end
  end

  assign dout                 = dout_q;
  assign edge_found           = edge_q;
  assign retry_count          = retry_q;
  assign sampling_timer_count = timer_q;
  assign sample_idle          = (state_q == IDLE);
  assign sample_valid         = (state_q == DONE) && sample_req;
  assign sample_fail          = (state_q == FAIL) && sample_req;
  // Masked by reset so an aborted CHECK cycle never reports an error.
  assign sample_error         = (state_q == CHECK) && any_amb && !reset;

endmodule

// File: tb/tb_clock_sample_multi.sv
module tb_clock_sample_multi;

  localparam int NCH = 2, CW = 4, MARGIN = 1, MAXR = 3, PSMIN = 2;
  localparam int WIN = 16, SLOT = WIN + 1, SEQ_N = SLOT * MAXR + 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [NCH-1:0] din;
  logic           sample_req;
  logic [7:0]     ps_shift_count;
  logic [NCH-1:0] dout;
  logic           sample_valid, sample_error, sample_fail, sample_idle;
  logic [NCH-1:0] edge_found;
  logic [7:0]     retry_count;
  logic [CW-1:0]  sampling_timer_count;

  int checks = 0;
  int failures = 0;

  // din value presented at each rising edge of a request, edge 0 being the
  // one that samples sample_req in IDLE.
  logic [NCH-1:0] din_seq [SEQ_N];
  logic [NCH-1:0] m_dout, m_edge;

  clock_sample_multi #(
    .NUM_CH(NCH), .CNT_WIDTH(CW), .STABLE_MARGIN(MARGIN),
    .MAX_RETRIES(MAXR), .PS_MIN(PSMIN)
  ) dut (
    .clock(clock), .reset(reset), .din(din), .sample_req(sample_req),
    .ps_shift_count(ps_shift_count), .dout(dout), .sample_valid(sample_valid),
    .sample_error(sample_error), .sample_fail(sample_fail), .sample_idle(sample_idle),
    .edge_found(edge_found), .retry_count(retry_count),
    .sampling_timer_count(sampling_timer_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic clear_seq();
    for (int n = 0; n < SEQ_N; n++) din_seq[n] = '0;
  endtask

  // kind: 0 all low, 1 all high, 2 fifteen high, 3 one high, 4 fourteen high,
  // 5 two high, 6 toggling, other random.
  task automatic fill_win(input int w, input int ch, input int kind);
    int  p1, p2, idx;
    logic b;
    p1 = $urandom_range(0, WIN - 1);
    p2 = (p1 + 1 + $urandom_range(0, WIN - 2)) % WIN;
    for (int j = 0; j < SLOT; j++) begin
      idx = w * SLOT + j;
      case (kind)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (j != p1);
        3: b = (j == p1);
        4: b = (j != p1) && (j != p2);
        5: b = (j == p1) || (j == p2);
        6: b = (idx % 2) == 1;
        default: b = 1'($urandom_range(0, 1));
      endcase
      if (j == WIN) b = 1'($urandom_range(0, 1));
      din_seq[idx][ch] = b;
    end
  endtask

  task automatic fill_req(input int k0, input int k1);
    clear_seq();
    for (int w = 0; w < MAXR; w++) begin
      fill_win(w, 0, k0);
      fill_win(w, 1, k1);
    end
  endtask

  // Runs one request from IDLE: model first, then drive and compare per cycle.
  task automatic run_request(input logic [7:0] ps, input bit pulse, input string tag);
    logic [NCH-1:0] r, old_dout;
    bit             amb, done;
    bit             amb_w [MAXR];
    int             ones, nwin, exp_retry, w, j;
    done = 0; exp_retry = 0; nwin = 0; r = '0;
    for (int k = 0; k < MAXR; k++) amb_w[k] = 0;
    for (int k = 0; k < MAXR; k++) begin
      amb = 0;
      for (int c = 0; c < NCH; c++) begin
        ones = 0;
        for (int s = 0; s < WIN; s++) ones += int'(din_seq[k * SLOT + s][c]);
        if (ones >= WIN - MARGIN) r[c] = 1'b1;
        else if (ones <= MARGIN) r[c] = 1'b0;
        else amb = 1;
      end
      amb_w[k] = amb;
      nwin = k + 1;
      if (!amb) begin
        done = 1;
        break;
      end
      exp_retry++;
    end
    old_dout = m_dout;
    if (done) begin
      if (ps >= 8'(PSMIN)) m_edge = m_edge | (m_dout & ~r);
      m_dout = r;
    end

    din = din_seq[0]; ps_shift_count = ps; sample_req = 1'b1;
    for (int n = 0; n < SLOT * nwin; n++) begin
      @(negedge clock);
      w = n / SLOT; j = n % SLOT;
      if (j < WIN) begin
        checks++;
        if (sampling_timer_count !== CW'(j)) begin failures++; $display("FAIL %s timer n=%0d: got %0d expected %0d", tag, n, sampling_timer_count, j); end
        checks++;
        if (sample_error !== 1'b0) begin failures++; $display("FAIL %s error_in_sample n=%0d: got %0b expected 0", tag, n, sample_error); end
        checks++;
        if (retry_count !== 8'(w)) begin failures++; $display("FAIL %s retry_in_window n=%0d: got %0d expected %0d", tag, n, retry_count, w); end
      end else begin
        checks++;
        if (sample_error !== amb_w[w]) begin failures++; $display("FAIL %s error_at_check w=%0d: got %0b expected %0b", tag, w, sample_error, amb_w[w]); end
        checks++;
        if (sampling_timer_count !== '0) begin failures++; $display("FAIL %s timer_at_check: got %0d expected 0", tag, sampling_timer_count); end
      end
      checks++;
      if ({sample_idle, sample_valid, sample_fail} !== 3'b000) begin failures++; $display("FAIL %s status_busy n=%0d: got %03b expected 000", tag, n, {sample_idle, sample_valid, sample_fail}); end
      checks++;
      if (dout !== old_dout) begin failures++; $display("FAIL %s dout_hold n=%0d: got %0b expected %0b", tag, n, dout, old_dout); end
      din = din_seq[n + 1];
      if (pulse) sample_req = 1'b0;
    end

    for (int h = 0; h < (pulse ? 1 : 2); h++) begin
      @(negedge clock);
      checks++;
      if (sample_valid !== (done && !pulse)) begin failures++; $display("FAIL %s valid: got %0b expected %0b", tag, sample_valid, done && !pulse); end
      checks++;
      if (sample_fail !== (!done && !pulse)) begin failures++; $display("FAIL %s fail_flag: got %0b expected %0b", tag, sample_fail, !done && !pulse); end
      checks++;
      if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL %s retry_final: got %0d expected %0d", tag, retry_count, exp_retry); end
      checks++;
      if (dout !== m_dout) begin failures++; $display("FAIL %s dout_final: got %0b expected %0b", tag, dout, m_dout); end
      checks++;
      if (edge_found !== m_edge) begin failures++; $display("FAIL %s edge_found: got %0b expected %0b", tag, edge_found, m_edge); end
      checks++;
      if ({sample_error, sample_idle} !== 2'b00) begin failures++; $display("FAIL %s err_idle_final: got %02b expected 00", tag, {sample_error, sample_idle}); end
    end

    sample_req = 1'b0;
    @(negedge clock);
    checks++;
    if ({sample_idle, sample_valid, sample_fail} !== 3'b100) begin failures++; $display("FAIL %s back_to_idle: got %03b expected 100", tag, {sample_idle, sample_valid, sample_fail}); end
    checks++;
    if (dout !== m_dout) begin failures++; $display("FAIL %s dout_retained: got %0b expected %0b", tag, dout, m_dout); end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_req = 1'b0; din = '1; ps_shift_count = 8'd0;
    repeat (3) @(negedge clock);
    checks++;
    if ({sample_idle, sample_valid, sample_fail, sample_error} !== 4'b1000) begin failures++; $display("FAIL reset_status: got %04b expected 1000", {sample_idle, sample_valid, sample_fail, sample_error}); end
    checks++;
    if ({dout, edge_found} !== '0) begin failures++; $display("FAIL reset_dout_edge: got %0b/%0b expected 0/0", dout, edge_found); end
    checks++;
    if ({retry_count, sampling_timer_count} !== '0) begin failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", retry_count, sampling_timer_count); end
    reset = 1'b0; din = '0;
    m_dout = '0; m_edge = '0;
    @(negedge clock);
  endtask

  task automatic test_constant();
    clear_seq();
    for (int n = 0; n < SEQ_N; n++) din_seq[n] = 2'b01;
    run_request(8'd0, 1'b1, "const_pulse");
    checks++;
    if (dout !== 2'b01) begin failures++; $display("FAIL const_dout: got %0b expected 01", dout); end
    run_request(8'd0, 1'b0, "const_hold");
  endtask

  task automatic test_margin();
    fill_req(2, 3);
    run_request(8'd0, 1'b0, "margin_15of16");
    checks++;
    if (dout !== 2'b01) begin failures++; $display("FAIL margin_dout: got %0b expected 01", dout); end
    fill_req(1, 0);
    fill_win(0, 0, 4);
    run_request(8'd0, 1'b0, "margin_14of16");
    fill_req(0, 0);
    fill_win(0, 1, 5);
    run_request(8'd0, 1'b0, "margin_2of16");
  endtask

  task automatic test_fail();
    fill_req(1, 6);
    run_request(8'd0, 1'b0, "fail_toggle");
    checks++;
    if (retry_count !== 8'd3) begin failures++; $display("FAIL fail_retry_count: got %0d expected 3", retry_count); end
  endtask

  task automatic test_edge();
    test_reset();
    fill_req(1, 1); run_request(8'd3, 1'b0, "edge_ps3_a");
    fill_req(1, 0); run_request(8'd3, 1'b0, "edge_ps3_b");
    checks++;
    if (edge_found !== 2'b10) begin failures++; $display("FAIL edge_ps3: got %0b expected 10", edge_found); end
    test_reset();
    fill_req(1, 1); run_request(8'd1, 1'b0, "edge_ps1_a");
    fill_req(1, 0); run_request(8'd1, 1'b0, "edge_ps1_b");
    checks++;
    if (edge_found !== 2'b00) begin failures++; $display("FAIL edge_ps1: got %0b expected 00", edge_found); end
  endtask

  task automatic test_random();
    int kinds [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    for (int t = 0; t < 10; t++) begin
      clear_seq();
      for (int w = 0; w < MAXR; w++) begin
        fill_win(w, 0, kinds[$urandom_range(0, 7)]);
        fill_win(w, 1, kinds[$urandom_range(0, 7)]);
      end
      run_request(8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    fill_req(1, 1);
    run_request(8'd0, 1'b0, "pre_abort");
    fill_req(7, 7);
    din = din_seq[0]; sample_req = 1'b1;
    hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clock);
      din = din_seq[(n + 1) % SEQ_N];
      if (sampling_timer_count == CW'(7) && !sample_idle) begin
        hit = 1;
        reset = 1'b1; sample_req = 1'b0;
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_reach_timer7: got no timer=7 expected timer=7 within 40 cycles"); end
    @(negedge clock);
    checks++;
    if ({sample_idle, sample_valid, sample_fail, sample_error} !== 4'b1000) begin failures++; $display("FAIL abort_status: got %04b expected 1000", {sample_idle, sample_valid, sample_fail, sample_error}); end
    checks++;
    if ({retry_count, sampling_timer_count} !== '0) begin failures++; $display("FAIL abort_counters: got %0d/%0d expected 0/0", retry_count, sampling_timer_count); end
    checks++;
    if ({dout, edge_found} !== '0) begin failures++; $display("FAIL abort_dout: got %0b/%0b expected 0/0", dout, edge_found); end
    reset = 1'b0;
    m_dout = '0; m_edge = '0;
    @(negedge clock);
    fill_req(1, 0);
    run_request(8'd0, 1'b0, "after_abort");
  endtask

  initial begin
    reset = 1'b1; sample_req = 1'b0; din = '0; ps_shift_count = 8'd0;
    m_dout = '0; m_edge = '0;
    test_reset();
    test_constant();
    test_margin();
    test_fail();
    test_edge();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
